// File: rtl/alu_display_core.sv
// alu_display_core: 4-bit ALU (add, subtract, shift-add multiply, AND) driving six
// active-low seven-segment digits that show "A op B = result".
module alu_display_core (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [1:0] Select,
  input  logic       Init,
  output logic       Cout,
  output logic       Done,
  output logic [7:0] Sal,
  output logic [6:0] oup_display1,
  output logic [6:0] oup_display2,
  output logic [6:0] oup_display3,
  output logic [6:0] oup_display4,
  output logic [6:0] oup_display5,
  output logic [6:0] oup_display6
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StIter = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  // Hex digit glyphs, segment order {g,f,e,d,c,b,a}, lit when 0.
  function automatic logic [6:0] digit_seg(input logic [3:0] val);
    case (val)
      4'h0: digit_seg = 7'b1000000;
      4'h1: digit_seg = 7'b1111001;
      4'h2: digit_seg = 7'b0100100;
      4'h3: digit_seg = 7'b0110000;
      4'h4: digit_seg = 7'b0011001;
      4'h5: digit_seg = 7'b0010010;
      4'h6: digit_seg = 7'b0000010;
      4'h7: digit_seg = 7'b1111000;
      4'h8: digit_seg = 7'b0000000;
      4'h9: digit_seg = 7'b0010000;
      4'hA: digit_seg = 7'b0001000;
      4'hB: digit_seg = 7'b0000011;
      4'hC: digit_seg = 7'b1000110;
      4'hD: digit_seg = 7'b0100001;
      4'hE: digit_seg = 7'b0000110;
      default: digit_seg = 7'b0001110;
    endcase
  endfunction

  // Operator glyphs: + - H A =, anything else blank.
  function automatic logic [6:0] op_seg(input logic [3:0] code);
    case (code)
      4'd0: op_seg = 7'b0110001;
      4'd1: op_seg = 7'b0111111;
      4'd2: op_seg = 7'b0001001;
      4'd3: op_seg = 7'b0001000;
      4'd4: op_seg = 7'b0110111;
      default: op_seg = 7'b1111111;
    endcase
  endfunction

  logic [1:0] state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] m_q, m_d;
  logic [3:0] q_q, q_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] p_q, p_d;
  logic       done_q, done_d;

  // Multiplier next-state. The IDLE->LOAD edge latches the operands, so the
  // first shift-add step already happens on the cycle spent in LOAD.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    q_d     = q_q;
    acc_d   = acc_q;
    p_d     = p_q;
    done_d  = done_q;
    case (state_q)
      StIdle: begin
        if (Init) begin
          m_d     = {4'b0000, A};
          q_d     = B;
          acc_d   = 8'h00;
          cnt_d   = 2'd0;
          done_d  = 1'b0;
          state_d = StLoad;
        end
      end
      StLoad, StIter: begin
        if (q_q[0]) acc_d = acc_q + m_q;
        m_d   = m_q << 1;
        q_d   = q_q >> 1;
        cnt_d = cnt_q + 2'd1;
        state_d = (cnt_q == 2'd3) ? StDone : StIter;
      end
      default: begin
        p_d    = acc_q;
        done_d = 1'b1;
        if (!Init) state_d = StIdle;
      end
    endcase
  end

  // Multiplier state registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      m_q     <= 8'h00;
      q_q     <= 4'h0;
      acc_q   <= 8'h00;
      p_q     <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      done_q  <= done_d;
    end
  end

  logic [4:0] sum;
  assign sum = {1'b0, A} + {1'b0, B};

  // Result mux: combinational ops, or the held product.
  always_comb begin
    Sal  = 8'h00;
    Cout = 1'b0;
    Done = 1'b1;
    case (Select)
      2'b00: begin
        Sal  = {3'b000, sum};
        Cout = sum[4];
      end
      2'b01: begin
        Cout = (A < B);
        Sal  = (A < B) ? {4'b0000, B - A} : {4'b0000, A - B};
      end
      2'b10: begin
        Sal  = p_q;
        Done = done_q;
      end
      default: Sal = {4'b0000, A & B};
    endcase
  end

  // Display digits.
  always_comb begin
    oup_display1 = digit_seg(A);
    oup_display2 = op_seg({2'b00, Select});
    oup_display3 = digit_seg(B);
    oup_display4 = (Select == 2'b01 && Cout) ? op_seg(4'd1) : op_seg(4'd4);
    oup_display5 = digit_seg(Sal[7:4]);
    oup_display6 = digit_seg(Sal[3:0]);
  end

endmodule

// File: tb/tb_alu_display_core.sv
// tb_alu_display_core: randomized checks of alu_display_core against an arithmetic model.
module tb_alu_display_core;

  logic       Clk;
  logic       Rst;
  logic [3:0] A, B;
  logic [1:0] Select;
  logic       Init;
  logic       Cout, Done;
  logic [7:0] Sal;
  logic [6:0] d1, d2, d3, d4, d5, d6;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic [6:0] op_tab [4] = '{7'b0110001, 7'b0111111, 7'b0001001, 7'b0001000};
  localparam logic [6:0] GlyphMinus = 7'b0111111;
  localparam logic [6:0] GlyphEq    = 7'b0110111;

  alu_display_core dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .A            (A),
    .B            (B),
    .Select       (Select),
    .Init         (Init),
    .Cout         (Cout),
    .Done         (Done),
    .Sal          (Sal),
    .oup_display1 (d1),
    .oup_display2 (d2),
    .oup_display3 (d3),
    .oup_display4 (d4),
    .oup_display5 (d5),
    .oup_display6 (d6)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply a combinational op and compare every output with the arithmetic model.
  task automatic check_comb(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel);
    int ia, ib, sal_e, cout_e;
    ia = int'(a);
    ib = int'(b);
    @(negedge Clk);
    A = a; B = b; Select = sel;
    #1;
    case (sel)
      2'd0: begin sal_e = ia + ib; cout_e = (ia + ib > 15) ? 1 : 0; end
      2'd1: begin sal_e = (ia >= ib) ? ia - ib : ib - ia; cout_e = (ia < ib) ? 1 : 0; end
      default: begin sal_e = int'(a & b); cout_e = 0; end
    endcase
    check("sal", 32'(Sal), sal_e);
    check("cout", 32'(Cout), cout_e);
    check("done_comb", 32'(Done), 1);
    check("d1", 32'(d1), 32'(seg_tab[ia]));
    check("d2", 32'(d2), 32'(op_tab[sel]));
    check("d3", 32'(d3), 32'(seg_tab[ib]));
    check("d4", 32'(d4), (sel == 2'd1 && ia < ib) ? 32'(GlyphMinus) : 32'(GlyphEq));
    check("d5", 32'(d5), 32'(seg_tab[sal_e / 16]));
    check("d6", 32'(d6), 32'(seg_tab[sal_e % 16]));
  endtask

  // One multiply: Init sampled at edge k, product expected after edge k+5.
  // Operands are scrambled after the start to show they are not re-read.
  task automatic run_mul(input logic [3:0] a, input logic [3:0] b, input bit hold);
    int prod;
    prod = int'(a) * int'(b);
    @(negedge Clk);
    A = a; B = b; Select = 2'b10; Init = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      check("mul_busy", 32'(Done), 0);
      @(negedge Clk);
      if (!hold) Init = 1'b0;
      A = 4'($urandom); B = 4'($urandom);
    end
    @(posedge Clk); #1;
    check("mul_done", 32'(Done), 1);
    check("mul_prod", 32'(Sal), prod);
    check("mul_d5", 32'(d5), 32'(seg_tab[prod / 16]));
    check("mul_d6", 32'(d6), 32'(seg_tab[prod % 16]));
    if (hold) begin
      for (int i = 0; i < 8; i++) begin
        @(posedge Clk); #1;
        check("hold_done", 32'(Done), 1);
        check("hold_prod", 32'(Sal), prod);
      end
      @(negedge Clk);
      Init = 1'b0;
      @(negedge Clk);
    end
  endtask

  initial begin
    Rst = 1'b0; Init = 1'b0; A = 4'h0; B = 4'h0; Select = 2'b10;
    #12;
    check("rst_sal", 32'(Sal), 0);
    check("rst_done", 32'(Done), 0);
    // Combinational path stays live under reset.
    check_comb(4'h9, 4'h8, 2'd0);
    @(negedge Clk);
    Rst = 1'b1;

    // Directed vectors.
    check_comb(4'h0, 4'h0, 2'd0);
    check_comb(4'h3, 4'h4, 2'd0);
    check_comb(4'h3, 4'h7, 2'd1);
    check_comb(4'h7, 4'h3, 2'd1);
    check_comb(4'hC, 4'hA, 2'd3);
    check_comb(4'hF, 4'hF, 2'd0);
    check_comb(4'h5, 4'h5, 2'd1);

    // Random combinational ops.
    for (int i = 0; i < 40; i++) begin
      logic [1:0] s;
      s = 2'($urandom_range(0, 2));
      if (s == 2'd2) s = 2'd3;
      check_comb(4'($urandom), 4'($urandom), s);
    end

    // Multiply: max operands with Init held, then release and re-pulse.
    run_mul(4'hF, 4'hF, 1'b1);
    run_mul(4'h5, 4'h3, 1'b0);
    for (int i = 0; i < 6; i++) run_mul(4'($urandom), 4'($urandom), 1'b0);
    run_mul(4'h0, 4'h9, 1'b0);

    // Reset mid-multiply aborts at once.
    @(negedge Clk);
    A = 4'hB; B = 4'hD; Select = 2'b10; Init = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Init = 1'b0;
    repeat (3) @(posedge Clk);
    #2 Rst = 1'b0;
    #1;
    check("abort_done", 32'(Done), 0);
    check("abort_sal", 32'(Sal), 0);
    @(negedge Clk);
    Rst = 1'b1;
    run_mul(4'hB, 4'hD, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
